bram_fifo_ctrl: RTL

- Controller that turns a 2k x 8 dual-port block RAM (write/read port A, registered read port B, one-cycle read latency) into a synchronous FIFO with valid/ready handshakes on both sides.
- Owns the write and read pointers, issues RAM reads ahead of demand, and holds prefetched words in a 2-entry output buffer so the output sustains 1 word/cycle.
- Sits between a byte producer (e.g. host/USB receive path) and a consumer (converter stream logic), with the RAM instantiated alongside it.

---
 rtl/bram_fifo_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller around a dual-port block RAM with a registered read port.
// Reads are issued ahead of demand into a two-entry output buffer (head + skid)
// so the output side can sustain one word per cycle despite the RAM latency.
module bram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] fill_count,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic [ADDR_WIDTH-1:0] ram_dpra,
  input  logic [DATA_WIDTH-1:0] ram_dpo,
  output logic                  ram_reset
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [ADDR_WIDTH+1:0] FILL_ONE = (ADDR_WIDTH + 2)'(1);

  logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic                  head_valid_q, head_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [ADDR_WIDTH+1:0] fill_q, fill_d;

  logic [PW-1:0] ram_words;
  logic          push, pop, issue;
  logic [2:0]    demand;

  // Handshake decode and read-ahead decision
  always_comb begin
    ram_words = wp_q - rp_q;
    in_ready  = (ram_words != DEPTH_P) && !flush;
    push      = in_valid && in_ready;
    pop       = head_valid_q && out_ready && !flush;
    // Words already owned by the output side (buffered or in flight); a pop frees one slot.
    demand    = {2'b00, head_valid_q} + {2'b00, skid_valid_q} + {2'b00, pending_q};
    issue     = (ram_words != '0) && !flush && (demand < (3'd2 + {2'b00, pop}));
  end

  // RAM port drive and visible outputs
  always_comb begin
    ram_we     = push;
    ram_a      = wp_q[ADDR_WIDTH-1:0];
    ram_di     = in_data;
    ram_dpra   = rp_q[ADDR_WIDTH-1:0];
    ram_reset  = 1'b0;
    out_data   = head_q;
    out_valid  = head_valid_q;
    fill_count = fill_q;
  end

  // Next-state: pointers, fill count and output buffer routing
  always_comb begin
    wp_d         = wp_q;
    rp_d         = rp_q;
    pending_d    = issue;
    head_d       = head_q;
    head_valid_d = head_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    fill_d       = fill_q;
    if (flush) begin
      wp_d         = '0;
      rp_d         = '0;
      pending_d    = 1'b0;
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      fill_d       = '0;
    end else begin
      if (push) wp_d = wp_q + PTR_ONE;
      if (issue) rp_d = rp_q + PTR_ONE;
      case ({push, pop})
        2'b10:   fill_d = fill_q + FILL_ONE;
        2'b01:   fill_d = fill_q - FILL_ONE;
        default: fill_d = fill_q;
      endcase
      // Skid always drains before the returning RAM word to keep order.
      if (pop) begin
        if (skid_valid_q) begin
          head_d       = skid_q;
          skid_valid_d = pending_q;
          if (pending_q) skid_d = ram_dpo;
        end else if (pending_q) begin
          head_d = ram_dpo;
        end else begin
          head_valid_d = 1'b0;
        end
      end else if (pending_q) begin
        if (!head_valid_q) begin
          head_d       = ram_dpo;
          head_valid_d = 1'b1;
        end else begin
          skid_d       = ram_dpo;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q         <= '0;
      rp_q         <= '0;
      pending_q    <= 1'b0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      fill_q       <= '0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      pending_q    <= pending_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      fill_q       <= fill_d;
    end
  end

endmodule
